// File: rtl/unet_blklist_fetch_sched_if.sv
// ----------------------------------------------------------------------------
// unet_blklist_fetch_sched_if
// Bus bundle for the U-Net block-list fetch scheduler.
//   m00_*  : AXI4-Lite read channels (block-list table walk)
//   m01_*  : AXI4 read channels (tile bursts, INCR, fixed length)
//   out_*  : valid/ready stream towards the accelerator input buffer
// modport master : scheduler side (drives addresses, valids of AR, readies of R,
//                  and the out stream payload/valid)
// modport slave  : memory/sink side (the reverse directions)
// ----------------------------------------------------------------------------
interface unet_blklist_fetch_sched_if;
    logic [31:0] m00_araddr;
    logic        m00_arvalid;
    logic        m00_arready;
    logic [31:0] m00_rdata;
    logic [1:0]  m00_rresp;
    logic        m00_rvalid;
    logic        m00_rready;

    logic [31:0] m01_araddr;
    logic [7:0]  m01_arlen;
    logic [2:0]  m01_arsize;
    logic [1:0]  m01_arburst;
    logic [11:0] m01_arid;
    logic        m01_arvalid;
    logic        m01_arready;
    logic [31:0] m01_rdata;
    logic [1:0]  m01_rresp;
    logic        m01_rlast;
    logic        m01_rvalid;
    logic        m01_rready;

    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output m00_araddr, m00_arvalid, m00_rready,
               m01_araddr, m01_arlen, m01_arsize, m01_arburst, m01_arid,
               m01_arvalid, m01_rready,
               out_data, out_valid, out_last,
        input  m00_arready, m00_rdata, m00_rresp, m00_rvalid,
               m01_arready, m01_rdata, m01_rresp, m01_rlast, m01_rvalid,
               out_ready
    );

    modport slave (
        input  m00_araddr, m00_arvalid, m00_rready,
               m01_araddr, m01_arlen, m01_arsize, m01_arburst, m01_arid,
               m01_arvalid, m01_rready,
               out_data, out_valid, out_last,
        output m00_arready, m00_rdata, m00_rresp, m00_rvalid,
               m01_arready, m01_rdata, m01_rresp, m01_rlast, m01_rvalid,
               out_ready
    );
endinterface

// File: rtl/unet_blklist_fetch_sched.sv
// ----------------------------------------------------------------------------
// unet_blklist_fetch_sched
// Walks a table of 32-bit tile base addresses over AXI4-Lite (M00) and, for
// each non-zero entry, issues one fixed-length INCR burst on AXI4 (M01). Burst
// beats pass straight through to the out stream; out_ready back-pressures M01.
// A zero entry or MAX_ENTRIES completed bursts ends the run; a bad response or
// a beat-count mismatch aborts it with the sticky error flag.
// Ports:
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   start         : 1-cycle pulse, begins a run when idle
//   list_base     : table byte address, sampled on accepted start
//   busy          : run in progress
//   done          : 1-cycle pulse at end of run (normal or error)
//   error         : sticky, cleared by the next accepted start
//   blk_count     : bursts completed in the current/last run
//   bus           : M00 / M01 / out stream bundle (master side)
// ----------------------------------------------------------------------------
module unet_blklist_fetch_sched #(
    parameter int          BURST_LEN   = 16,
    parameter int          MAX_ENTRIES = 64,
    parameter logic [11:0] AXI_ID      = 12'h0
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        start,
    input  logic [31:0] list_base,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  blk_count,
    unet_blklist_fetch_sched_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LST_AR = 3'd1;
    localparam logic [2:0] S_LST_R  = 3'd2;
    localparam logic [2:0] S_BST_AR = 3'd3;
    localparam logic [2:0] S_BST_R  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [8:0]  BLEN_W    = 9'(BURST_LEN);
    localparam logic [8:0]  MAXE_W    = 9'(MAX_ENTRIES);
    // Aligning the tile base to the burst footprint keeps every burst inside
    // one 4 KB page.
    localparam logic [31:0] BASE_MASK = ~(32'(BURST_LEN * 4) - 32'd1);

    logic [2:0]  state;
    logic [31:0] list_base_q;
    logic [31:0] burst_base;
    logic [8:0]  beat_cnt;
    logic        pend_err;

    logic        in_bst_r;
    logic        beat_fire;
    logic [8:0]  beat_nxt;
    logic [8:0]  blk_nxt;

    assign in_bst_r  = (state == S_BST_R);
    assign beat_fire = in_bst_r && bus.m01_rvalid && bus.out_ready;
    assign beat_nxt  = beat_cnt + 9'd1;
    assign blk_nxt   = blk_count + 9'd1;

    // Table index equals the number of bursts completed so far: both start at
    // zero and advance together on each good burst, so blk_count doubles as idx.
    assign bus.m00_araddr  = list_base_q + {21'd0, blk_count, 2'b00};
    assign bus.m00_arvalid = (state == S_LST_AR);
    assign bus.m00_rready  = (state == S_LST_R);

    assign bus.m01_araddr  = burst_base;
    assign bus.m01_arlen   = 8'(BURST_LEN - 1);
    assign bus.m01_arsize  = 3'b010;
    assign bus.m01_arburst = 2'b01;
    assign bus.m01_arid    = AXI_ID;
    assign bus.m01_arvalid = (state == S_BST_AR);

    // Pure pass-through: no skid buffer, so the sink's ready is M01's ready.
    assign bus.m01_rready = in_bst_r && bus.out_ready;
    assign bus.out_valid  = in_bst_r && bus.m01_rvalid;
    assign bus.out_last   = in_bst_r && bus.m01_rlast;
    assign bus.out_data   = bus.m01_rdata;

    assign busy = (state == S_LST_AR) || (state == S_LST_R) ||
                  (state == S_BST_AR) || (state == S_BST_R);
    assign done = (state == S_DONE) || (state == S_ERR);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= S_IDLE;
            list_base_q <= '0;
            burst_base  <= '0;
            beat_cnt    <= '0;
            pend_err    <= 1'b0;
            error       <= 1'b0;
            blk_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        list_base_q <= {list_base[31:2], 2'b00};
                        blk_count   <= '0;
                        error       <= 1'b0;
                        state       <= S_LST_AR;
                    end
                end
                S_LST_AR: begin
                    if (bus.m00_arready) state <= S_LST_R;
                end
                S_LST_R: begin
                    if (bus.m00_rvalid) begin
                        if (bus.m00_rresp != 2'b00) begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end else if (bus.m00_rdata == 32'd0) begin
                            state <= S_DONE;
                        end else begin
                            burst_base <= bus.m00_rdata & BASE_MASK;
                            state      <= S_BST_AR;
                        end
                    end
                end
                S_BST_AR: begin
                    if (bus.m01_arready) begin
                        beat_cnt <= '0;
                        pend_err <= 1'b0;
                        state    <= S_BST_R;
                    end
                end
                S_BST_R: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_nxt;
                        if (bus.m01_rlast) begin
                            if (beat_nxt != BLEN_W || pend_err ||
                                bus.m01_rresp != 2'b00) begin
                                error <= 1'b1;
                                state <= S_ERR;
                            end else begin
                                blk_count <= blk_nxt;
                                state     <= (blk_nxt == MAXE_W) ? S_DONE : S_LST_AR;
                            end
                        end else if (bus.m01_rresp != 2'b00 || beat_nxt == BLEN_W) begin
                            // A bad beat, or a full burst without rlast (late
                            // rlast): remember it and keep draining to rlast.
                            pend_err <= 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unet_blklist_fetch_sched.sv
// ----------------------------------------------------------------------------
// tb_unet_blklist_fetch_sched
// Self-checking bench: memory/sink responders with optional random delays, a
// table-walk reference model computing expected M00/M01 addresses, out beats,
// blk_count and error, and a directed test sequence in one initial block.
// ----------------------------------------------------------------------------
module tb_unet_blklist_fetch_sched;
    localparam int BLEN  = 16;
    localparam int MAX_E = 3;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        start;
    logic [31:0] list_base;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  blk_count;

    unet_blklist_fetch_sched_if bus();

    unet_blklist_fetch_sched #(
        .BURST_LEN  (BLEN),
        .MAX_ENTRIES(MAX_E),
        .AXI_ID     (12'h0)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .start    (start),
        .list_base(list_base),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .blk_count(blk_count),
        .bus      (bus)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // Table memory seen by the M00 responder.
    logic [31:0] mem [logic [31:0]];

    // Responder controls.
    bit rand_en  = 1'b0;
    int out_mode = 0;   // 0 always ready, 1 toggle, 2 random
    int err_burst = -1; // burst index that gets RRESP=SLVERR on beat 5

    // Responder state.
    bit          m00_pend, m00_hold, m01_pend, m01_hold;
    logic [31:0] m00_addr, m01_addr;
    int          m01_beat, cur_burst, burst_no;
    int          rr_viol, attr_viol;

    // Observations and expectations.
    logic [31:0] obs_m00[$], obs_m01[$], exp_m00[$], exp_m01[$];
    logic [32:0] obs_beats[$], exp_beats[$];
    int          exp_blk;
    bit          exp_err;

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int k);
        return (a + 32'(k) * 32'd4) ^ 32'hC3C3_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Responders and monitor: drive on the falling edge, then record which
    // handshakes will complete on the coming rising edge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            bus.m00_arready = 1'b0; bus.m00_rvalid = 1'b0;
            bus.m00_rdata   = '0;   bus.m00_rresp  = '0;
            bus.m01_arready = 1'b0; bus.m01_rvalid = 1'b0;
            bus.m01_rdata   = '0;   bus.m01_rresp  = '0; bus.m01_rlast = 1'b0;
            bus.out_ready   = 1'b0;
            m00_pend = 0; m00_hold = 0; m01_pend = 0; m01_hold = 0;
        end else begin
            bus.m00_arready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.m01_arready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m00_pend) begin
                if (!m00_hold) begin
                    bus.m00_rvalid = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                    bus.m00_rdata  = mem.exists(m00_addr) ? mem[m00_addr] : 32'h0;
                    bus.m00_rresp  = 2'b00;
                    m00_hold       = bus.m00_rvalid;
                end
            end else begin
                bus.m00_rvalid = 1'b0;
            end
            if (m01_pend) begin
                if (!m01_hold) begin
                    bus.m01_rvalid = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                    bus.m01_rdata  = beat_data(m01_addr, m01_beat);
                    bus.m01_rlast  = (m01_beat == BLEN - 1);
                    bus.m01_rresp  = (cur_burst == err_burst && m01_beat == 4) ? 2'b10 : 2'b00;
                    m01_hold       = bus.m01_rvalid;
                end
            end else begin
                bus.m01_rvalid = 1'b0;
            end
            case (out_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        #1;
        if (ARESETN) begin
            if (bus.m00_rvalid && bus.m00_rready) begin
                m00_pend = 0; m00_hold = 0;
            end
            if (bus.m00_arvalid && bus.m00_arready) begin
                obs_m00.push_back(bus.m00_araddr);
                m00_pend = 1; m00_addr = bus.m00_araddr;
            end
            if (bus.m01_rvalid && bus.m01_rready) begin
                m01_hold = 0; m01_beat++;
                if (m01_beat == BLEN) m01_pend = 0;
            end
            if (bus.m01_arvalid && bus.m01_arready) begin
                obs_m01.push_back(bus.m01_araddr);
                if ({bus.m01_arid, bus.m01_arburst, bus.m01_arsize, bus.m01_arlen} !==
                    {12'h0, 2'b01, 3'b010, 8'(BLEN - 1)}) attr_viol++;
                m01_pend = 1; m01_addr = bus.m01_araddr; m01_beat = 0;
                cur_burst = burst_no; burst_no++;
            end
            if (bus.out_valid && bus.m01_rready !== bus.out_ready) rr_viol++;
            if (bus.out_valid && bus.out_ready) obs_beats.push_back({bus.out_last, bus.out_data});
        end
    end

    // Reference model: walk the table as the scheduler should.
    task automatic build_expect(input logic [31:0] lb, input int eb);
        logic [31:0] a, e, b;
        exp_m00.delete(); exp_m01.delete(); exp_beats.delete();
        exp_blk = 0; exp_err = 0;
        for (int i = 0; i < MAX_E; i++) begin
            a = {lb[31:2], 2'b00} + 32'(i) * 32'd4;
            exp_m00.push_back(a);
            e = mem.exists(a) ? mem[a] : 32'h0;
            if (e == 32'h0) break;
            b = e & ~(32'(BLEN * 4) - 32'd1);
            exp_m01.push_back(b);
            for (int k = 0; k < BLEN; k++) exp_beats.push_back({k == BLEN - 1, beat_data(b, k)});
            if (i == eb) begin
                exp_err = 1;
                break;
            end
            exp_blk++;
        end
    endtask

    task automatic start_run(input string tag, input logic [31:0] lb);
        obs_m00.delete(); obs_m01.delete(); obs_beats.delete();
        burst_no = 0; rr_viol = 0; attr_viol = 0;
        @(negedge ACLK);
        start = 1'b1; list_base = lb;
        @(negedge ACLK);
        start = 1'b0;
        #2;
        check({tag, "_arvalid_lat"}, 64'(bus.m00_arvalid), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_err_clr"}, 64'(error), 64'd0);
        check({tag, "_araddr0"}, 64'(bus.m00_araddr), 64'(exp_m00[0]));
    endtask

    task automatic wait_done(input string tag);
        bit got = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge ACLK); #2;
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        check({tag, "_done"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            check({tag, "_blk_count"}, 64'(blk_count), 64'(exp_blk));
            check({tag, "_error"}, 64'(error), 64'(exp_err));
            @(negedge ACLK); #2;
            check({tag, "_done_pulse"}, 64'(done), 64'd0);
            check({tag, "_error_hold"}, 64'(error), 64'(exp_err));
        end
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_n_m00"}, 64'(obs_m00.size()), 64'(exp_m00.size()));
        for (int i = 0; i < obs_m00.size() && i < exp_m00.size(); i++)
            check($sformatf("%s_m00_%0d", tag, i), 64'(obs_m00[i]), 64'(exp_m00[i]));
        check({tag, "_n_m01"}, 64'(obs_m01.size()), 64'(exp_m01.size()));
        for (int i = 0; i < obs_m01.size() && i < exp_m01.size(); i++)
            check($sformatf("%s_m01_%0d", tag, i), 64'(obs_m01[i]), 64'(exp_m01[i]));
        check({tag, "_n_beats"}, 64'(obs_beats.size()), 64'(exp_beats.size()));
        for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++)
            check($sformatf("%s_beat_%0d", tag, i), 64'(obs_beats[i]), 64'(exp_beats[i]));
        check({tag, "_rready_eq"}, 64'(rr_viol), 64'd0);
        check({tag, "_ar_attr"}, 64'(attr_viol), 64'd0);
    endtask

    task automatic do_test(input string tag, input logic [31:0] lb, input int eb);
        err_burst = eb;
        build_expect(lb, eb);
        start_run(tag, lb);
        wait_done(tag);
        check_queues(tag);
    endtask

    task automatic load_t1();
        mem.delete();
        mem[32'h4580_0000] = 32'h1000_0000;
        mem[32'h4580_0004] = 32'h1000_0040;
        mem[32'h4580_0008] = 32'h0000_0000;
    endtask

    initial begin
        logic [31:0] lb, e;
        int n;
        bit got;
        ARESETN = 1'b0; start = 1'b0; list_base = '0;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK); #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_blk", 64'(blk_count), 64'd0);
        check("rst_m00_arvalid", 64'(bus.m00_arvalid), 64'd0);
        check("rst_m01_arvalid", 64'(bus.m01_arvalid), 64'd0);
        check("rst_m00_araddr", 64'(bus.m00_araddr), 64'd0);
        check("rst_m01_araddr", 64'(bus.m01_araddr), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);

        // T1: two tiles then terminator, zero-wait responders.
        load_t1();
        do_test("t1", 32'h4580_0000, -1);

        // T2: unaligned entry masked to 64 B; list_base low bits forced to 0.
        mem.delete();
        mem[32'h0000_2000] = 32'h1000_0013;
        mem[32'h0000_2004] = 32'h0;
        do_test("t2", 32'h0000_2002, -1);

        // T3: random tables, random handshake delays, out_ready toggle/random.
        rand_en = 1'b1;
        for (int it = 0; it < 4; it++) begin
            out_mode = (it % 2 == 0) ? 1 : 2;
            mem.delete();
            lb = $urandom;
            n  = $urandom_range(0, MAX_E);
            for (int i = 0; i < n; i++) begin
                e = $urandom | 32'h8000_0000;
                mem[{lb[31:2], 2'b00} + 32'(i) * 32'd4] = e;
            end
            mem[{lb[31:2], 2'b00} + 32'(n) * 32'd4] = 32'h0;
            do_test($sformatf("t3_%0d", it), lb, -1);
        end
        rand_en = 1'b0; out_mode = 0;

        // T4: SLVERR on beat 5 of the second burst, then a clean run clears error.
        mem.delete();
        mem[32'h5000_0000] = 32'h5000_1000;
        mem[32'h5000_0004] = 32'h5000_1400;
        mem[32'h5000_0008] = 32'h0;
        do_test("t4", 32'h5000_0000, 1);
        load_t1();
        do_test("t4_clear", 32'h4580_0000, -1);

        // T5: more non-zero entries than MAX_ENTRIES.
        mem.delete();
        for (int i = 0; i < 4; i++) mem[32'h7000_0000 + 32'(i) * 32'd4] = 32'h7100_0000 + 32'(i) * 32'h100;
        do_test("t5", 32'h7000_0000, -1);

        // T6: reset in the middle of a burst, then a fresh T1 run.
        load_t1();
        err_burst = -1;
        build_expect(32'h4580_0000, -1);
        start_run("t6a", 32'h4580_0000);
        got = 0;
        for (int c = 0; c < 500; c++) begin
            @(posedge ACLK);
            if (obs_beats.size() >= 7) begin
                got = 1;
                break;
            end
        end
        check("t6_reach_beat7", 64'(got), 64'd1);
        #3 ARESETN = 1'b0;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_m01_rready", 64'(bus.m01_rready), 64'd0);
        check("t6_m00_rready", 64'(bus.m00_rready), 64'd0);
        check("t6_arvalids", 64'({bus.m00_arvalid, bus.m01_arvalid}), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_blk", 64'(blk_count), 64'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        do_test("t6b", 32'h4580_0000, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
